// File: rtl/jtag_host_if.sv
// Command/response port of jtag_host: a valid/ready command channel carrying
// the scan request and a valid/ready response channel returning captured TDO.
interface jtag_host_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  // Requester side (debug master / bench).
  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  // jtag_host side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_host.sv
// Host-side JTAG driver. Turns TAP-reset / IR-scan / DR-scan commands into
// TCK/TMS/TDI sequences that start and end in Run-Test/Idle, captures TDO
// on the shift bits and returns it on the response channel.
// Optional feature: define JTAG_HOST_TRST_EN to drive jtag_trstn low during
// every TAP-reset sequence; otherwise jtag_trstn is tied high.
module jtag_host #(
  parameter int CLK_DIV = 2  // clk cycles per TCK half-period, >= 1
) (
  input  logic       clk,
  input  logic       rst,
  jtag_host_if.slave bus,
  output logic       busy,
  output logic       jtag_tck,
  output logic       jtag_tms,
  output logic       jtag_tdi,
  output logic       jtag_trstn,
  input  logic       jtag_tdo
);

  localparam int              DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
  localparam int              SW        = 38;  // 32 shift bits + 6 framing TCKs
  localparam logic [SW-1:0]   RESET_TMS = SW'(6'b011111);  // TMS 1,1,1,1,1,0

  typedef enum logic [1:0] {INIT_RST, IDLE, SHIFT_SEQ, RESP} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;          // clk count inside a TCK half-period
  logic          tck_q, tck_d;
  logic          tms_q, tms_d;
  logic          tdi_q, tdi_d;
  logic [5:0]    bit_q, bit_d;          // index of the current TCK
  logic [5:0]    last_q, last_d;        // index of the final TCK
  logic [5:0]    start_q, start_d;      // index of shift bit 0
  logic [5:0]    len_q, len_d;          // shift bits; 0 for TAP reset
  logic [SW-1:0] tms_seq_q, tms_seq_d;  // TMS value for every TCK index
  logic [31:0]   tdi_sr_q, tdi_sr_d;    // remaining TDI bits, LSB next
  logic [31:0]   cap_q, cap_d;          // TDO shifted in from the top
  logic          done_q, done_d;        // last TCK has fallen
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
`ifdef JTAG_HOST_TRST_EN
  logic          trstn_q, trstn_d;
  logic          rst_seq_q, rst_seq_d;  // running a TAP-reset sequence
`endif

  logic [5:0] bit_nxt;
  logic       shift_cur;
  logic       shift_nxt;
  logic       cmd_bad;

  assign bit_nxt   = bit_q + 6'd1;
  assign shift_cur = (bit_q >= start_q) && (bit_q < start_q + len_q);
  assign shift_nxt = (bit_nxt >= start_q) && (bit_nxt < start_q + len_q);
  assign cmd_bad   = (bus.cmd_op == 2'd3) || (bus.cmd_len == 6'd0) ||
                     (bus.cmd_len > 6'd32);

  // Next-state logic: command decode, TCK divider, TMS/TDI stepping, capture.
  always_comb begin
    // NOTE: every _d first takes its hold value, so no path through the case
    // below leaves a signal unassigned and no latch can be inferred.
    state_d    = state_q;
    div_d      = div_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    bit_d      = bit_q;
    last_d     = last_q;
    start_d    = start_q;
    len_d      = len_q;
    tms_seq_d  = tms_seq_q;
    tdi_sr_d   = tdi_sr_q;
    cap_d      = cap_q;
    done_d     = done_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
`ifdef JTAG_HOST_TRST_EN
    trstn_d    = trstn_q;
    rst_seq_d  = rst_seq_q;
`endif

    case (state_q)
      INIT_RST, SHIFT_SEQ: begin
        if (done_q) begin
          // One idle clk after the final falling edge, then hand over.
          done_d = 1'b0;
          if (state_q == INIT_RST) begin
            state_d = IDLE;
          end else begin
            state_d    = RESP;
            rsp_data_d = cap_q >> (6'd32 - len_q);
            rsp_err_d  = 1'b0;
          end
        end else if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          tck_d = ~tck_q;
          if (!tck_q) begin
            // Rising edge: the target has already presented this bit's TDO.
            if (shift_cur) cap_d = {jtag_tdo, cap_q[31:1]};
          end else if (bit_q == last_q) begin
            done_d = 1'b1;
          end else begin
            // Falling edge: present TMS/TDI for the next TCK.
            bit_d = bit_nxt;
            tms_d = tms_seq_q[bit_nxt];
            tdi_d = shift_nxt & tdi_sr_q[0];
            if (shift_nxt) tdi_sr_d = tdi_sr_q >> 1;
`ifdef JTAG_HOST_TRST_EN
            trstn_d = !(rst_seq_q && tms_seq_q[bit_nxt]);
`endif
          end
        end
      end

      IDLE: begin
        if (bus.cmd_valid) begin
          bit_d  = '0;
          div_d  = '0;
          cap_d  = '0;
          tdi_d  = 1'b0;
          done_d = 1'b0;
          if (cmd_bad) begin
            state_d    = RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d  = SHIFT_SEQ;
            tdi_sr_d = bus.cmd_data;
            len_d    = bus.cmd_len;
            case (bus.cmd_op)
              2'd0: begin  // 1 x5, 0
                tms_seq_d = RESET_TMS;
                last_d    = 6'd5;
                start_d   = 6'd0;
                len_d     = 6'd0;
              end
              2'd1: begin  // 1,1,0,0, shift (last bit 1), 1,0
                tms_seq_d = SW'(2'b11) | (SW'(2'b11) << (bus.cmd_len + 6'd3));
                last_d    = bus.cmd_len + 6'd5;
                start_d   = 6'd4;
              end
              default: begin  // DR: 1,0,0, shift (last bit 1), 1,0
                tms_seq_d = SW'(1'b1) | (SW'(2'b11) << (bus.cmd_len + 6'd2));
                last_d    = bus.cmd_len + 6'd4;
                start_d   = 6'd3;
              end
            endcase
            tms_d = tms_seq_d[0];
`ifdef JTAG_HOST_TRST_EN
            rst_seq_d = (bus.cmd_op == 2'd0);
            trstn_d   = (bus.cmd_op != 2'd0);
`endif
          end
        end
      end

      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end

      default: state_d = INIT_RST;
    endcase
  end

  // State register; reset loads the automatic TAP-reset sequence.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the same
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= INIT_RST;
      div_q      <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      bit_q      <= '0;
      last_q     <= 6'd5;
      start_q    <= '0;
      len_q      <= '0;
      tms_seq_q  <= RESET_TMS;
      tdi_sr_q   <= '0;
      cap_q      <= '0;
      done_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef JTAG_HOST_TRST_EN
      trstn_q    <= 1'b0;  // masked to 1 by rst at the output
      rst_seq_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      start_q    <= start_d;
      len_q      <= len_d;
      tms_seq_q  <= tms_seq_d;
      tdi_sr_q   <= tdi_sr_d;
      cap_q      <= cap_d;
      done_q     <= done_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
`ifdef JTAG_HOST_TRST_EN
      trstn_q    <= trstn_d;
      rst_seq_q  <= rst_seq_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != IDLE);
  assign jtag_tck      = tck_q;
  assign jtag_tms      = tms_q;
  assign jtag_tdi      = tdi_q;
`ifdef JTAG_HOST_TRST_EN
  // High while rst is held, low from the first INIT_RST clk onward.
  assign jtag_trstn    = trstn_q | rst;
`else
  assign jtag_trstn    = 1'b1;
`endif

endmodule

// File: tb/tb_jtag_host.sv
// Self-checking bench for jtag_host. A behavioural model builds each
// expected TMS/TDI/TRSTn sequence and response from the TAP walk rules; a
// random TDO pattern (or a TDI loopback) plays the target.
`timescale 1ns/1ps
module tb_jtag_host;
  localparam int CLK_DIV = 2;
`ifdef JTAG_HOST_TRST_EN
  localparam bit TRST_EN = 1'b1;
`else
  localparam bit TRST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy, jtag_tck, jtag_tms, jtag_tdi, jtag_trstn, jtag_tdo;

  jtag_host_if bus ();

  jtag_host #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .jtag_tck  (jtag_tck),
    .jtag_tms  (jtag_tms),
    .jtag_tdi  (jtag_tdi),
    .jtag_trstn(jtag_trstn),
    .jtag_tdo  (jtag_tdo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Target stand-in: TDO for TCK k is pat[k], updated after each rising edge.
  bit        loopback = 1'b0;
  logic      tdo_q = 1'b0;
  bit [63:0] pat;
  int        tck_cnt = 0;
  bit [63:0] obs_tms, obs_tdi, obs_trst;

  assign jtag_tdo = loopback ? jtag_tdi : tdo_q;

  // Record TMS/TDI/TRSTn as the target sees them on every TCK rising edge.
  always @(posedge jtag_tck) begin
    if (tck_cnt < 64) begin
      obs_tms[tck_cnt]  = jtag_tms;
      obs_tdi[tck_cnt]  = jtag_tdi;
      obs_trst[tck_cnt] = jtag_trstn;
    end
    tck_cnt++;
    if (tck_cnt < 64) tdo_q = pat[tck_cnt];
  end

  // TMS/TDI must not move while TCK is high (including across its rise).
  logic prev_tms = 1'b1, prev_tdi = 1'b0;
  always @(negedge clk) begin
    if (jtag_tck === 1'b1) begin
      checks++;
      if (jtag_tms !== prev_tms || jtag_tdi !== prev_tdi) begin
        errors++;
        $display("FAIL tms_tdi_stable @%0t: tms/tdi=%b%b was %b%b", $time,
                 jtag_tms, jtag_tdi, prev_tms, prev_tdi);
      end
    end
    prev_tms = jtag_tms;
    prev_tdi = jtag_tdi;
  end

  // Reference model: TAP walk Idle -> (Select-DR [-> Select-IR]) -> Capture
  // -> Shift -> Exit1 -> Update -> Idle, one TMS value per TCK.
  function automatic void model(input logic [1:0] op, input logic [5:0] len,
                                input logic [31:0] data, input bit [63:0] tdo_bits,
                                input bit lb, output bit [31:0] rsp, output bit err,
                                output int n, output bit [63:0] tms,
                                output bit [63:0] tdi);
    int p;
    int l;
    l = int'(len);
    rsp = '0; tms = '0; tdi = '0; n = 0;
    err = (op == 2'd3) || (l == 0) || (l > 32);
    if (err) return;
    if (op == 2'd0) begin
      tms[4:0] = 5'b11111;
      n = 6;
      return;
    end
    p = 0;
    tms[p] = 1'b1; p++;
    if (op == 2'd1) begin tms[p] = 1'b1; p++; end
    tms[p] = 1'b0; p++;
    tms[p] = 1'b0; p++;
    for (int i = 0; i < l; i++) begin
      tms[p] = (i == l - 1);
      tdi[p] = data[i];
      rsp[i] = lb ? data[i] : tdo_bits[p];
      p++;
    end
    tms[p] = 1'b1; p++;
    tms[p] = 1'b0; p++;
    n = p;
  endfunction

  function automatic bit [63:0] exp_trst(input bit reset_op, input int n);
    bit [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    if (reset_op && TRST_EN)
      for (int i = 0; i < n - 1; i++) v[i] = 1'b0;
    return v;
  endfunction

  // Drive one command through both handshakes; every wait is bounded.
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len,
                         input logic [31:0] data, input int hold,
                         output logic [31:0] r_data, output logic r_err,
                         output int lat, output bit hold_ok,
                         output bit rdy_after, output bit to);
    int w;
    to = 1'b0; hold_ok = 1'b1; rdy_after = 1'b0; lat = 0;
    r_data = '0; r_err = 1'b0;
    @(negedge clk);
    tck_cnt = 0; tdo_q = pat[0];
    obs_tms = '0; obs_tdi = '0; obs_trst = '0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    w = 0;
    while (!bus.cmd_ready && w < 200) begin @(negedge clk); w++; end
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      to = 1'b1;
      return;
    end
    // Accepted on the coming posedge; lat counts falling clk edges after it.
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
    if (!bus.rsp_valid) begin
      to = 1'b1;
      return;
    end
    r_data = bus.rsp_data;
    r_err  = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0) hold_ok = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    rdy_after = bus.cmd_ready;
  endtask

  // Run one command and compare everything observable against the model.
  task automatic test_cmd(input string name, input logic [1:0] op,
                          input logic [5:0] len, input logic [31:0] data,
                          input int hold);
    bit [31:0]   e_data;
    bit          e_err;
    int          e_n, e_lat;
    bit [63:0]   e_tms, e_tdi, e_trst;
    logic [31:0] r_data;
    logic        r_err;
    int          lat;
    bit          hold_ok, rdy_after, to;

    pat = {$urandom, $urandom};
    model(op, len, data, pat, loopback, e_data, e_err, e_n, e_tms, e_tdi);
    e_trst = exp_trst(op == 2'd0, e_n);
    // rsp_valid rises the clk after acceptance for errors, otherwise the
    // clk after the last TCK falls (2*CLK_DIV clk per TCK).
    e_lat  = e_err ? 1 : 2 * CLK_DIV * e_n + 2;
    run_cmd(op, len, data, hold, r_data, r_err, lat, hold_ok, rdy_after, to);

    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s timeout: handshake did not complete", name);
      return;
    end
    checks++;
    if (r_err !== e_err) begin
      errors++; $display("FAIL %s rsp_err: got %b expected %b", name, r_err, e_err);
    end
    checks++;
    if (r_data !== e_data) begin
      errors++; $display("FAIL %s rsp_data: got %h expected %h", name, r_data, e_data);
    end
    checks++;
    if (tck_cnt !== e_n) begin
      errors++; $display("FAIL %s tck_count: got %0d expected %0d", name, tck_cnt, e_n);
    end
    checks++;
    if (obs_tms !== e_tms) begin
      errors++; $display("FAIL %s tms_seq: got %h expected %h", name, obs_tms, e_tms);
    end
    checks++;
    if (obs_tdi !== e_tdi) begin
      errors++; $display("FAIL %s tdi_seq: got %h expected %h", name, obs_tdi, e_tdi);
    end
    checks++;
    if (obs_trst !== e_trst) begin
      errors++; $display("FAIL %s trstn_seq: got %h expected %h", name, obs_trst, e_trst);
    end
    checks++;
    if (lat !== e_lat) begin
      errors++; $display("FAIL %s rsp_latency: got %0d expected %0d", name, lat, e_lat);
    end
    checks++;
    if (rdy_after !== 1'b1 || jtag_tck !== 1'b0) begin
      errors++;
      $display("FAIL %s after_rsp: cmd_ready=%b tck=%b expected 1 0", name, rdy_after, jtag_tck);
    end
    if (hold > 0) begin
      checks++;
      if (!hold_ok) begin
        errors++; $display("FAIL %s rsp_hold: rsp_valid dropped or cmd_ready rose", name);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({jtag_tck, jtag_tms, jtag_tdi, jtag_trstn, bus.cmd_ready, bus.rsp_valid,
         bus.rsp_err, busy} !== 8'b0101_0001 || bus.rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: tck tms tdi trstn rdy vld err busy=%b%b%b%b%b%b%b%b data=%h expected 01010001 0",
               jtag_tck, jtag_tms, jtag_tdi, jtag_trstn, bus.cmd_ready,
               bus.rsp_valid, bus.rsp_err, busy, bus.rsp_data);
    end
  endtask

  // Release reset and check the automatic TAP-reset walk.
  task automatic release_and_check_init(input string name);
    int  w;
    bit  saw_rsp;
    tck_cnt = 0; obs_tms = '0; obs_tdi = '0; obs_trst = '0;
    rst = 1'b0;
    w = 0; saw_rsp = 1'b0;
    while (!bus.cmd_ready && w < 500) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_rsp = 1'b1;
      w++;
    end
    checks++;
    if (tck_cnt !== 6 || obs_tms !== 64'h1F || obs_tdi !== 64'h0) begin
      errors++;
      $display("FAIL %s tck/tms/tdi: got %0d %h %h expected 6 1f 0", name, tck_cnt, obs_tms, obs_tdi);
    end
    checks++;
    if (obs_trst !== exp_trst(1'b1, 6)) begin
      errors++;
      $display("FAIL %s trstn_seq: got %h expected %h", name, obs_trst, exp_trst(1'b1, 6));
    end
    checks++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || saw_rsp) begin
      errors++;
      $display("FAIL %s idle: cmd_ready=%b busy=%b rsp_seen=%b expected 1 0 0", name,
               bus.cmd_ready, busy, saw_rsp);
    end
  endtask

  task automatic test_init_rst();
    @(negedge clk);
    release_and_check_init("init_rst");
  endtask

  task automatic test_scans();
    test_cmd("tap_reset", 2'd0, 6'd0, 32'hFFFF_FFFF, 0);
    test_cmd("ir4_idcode", 2'd1, 6'd4, 32'h1, 0);
    test_cmd("dr32_zero", 2'd2, 6'd32, 32'h0, 0);
    test_cmd("ir1", 2'd1, 6'd1, 32'h1, 0);
    test_cmd("dr1", 2'd2, 6'd1, 32'h0, 0);
    test_cmd("ir32", 2'd1, 6'd32, $urandom, 0);
    for (int i = 0; i < 12; i++) begin
      test_cmd("random", 2'($urandom_range(0, 2)), 6'($urandom_range(1, 32)),
               $urandom, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_loopback();
    loopback = 1'b1;
    test_cmd("dr8_loopback", 2'd2, 6'd8, 32'hFFFF_FFA5, 0);
    loopback = 1'b0;
  endtask

  task automatic test_errors();
    test_cmd("err_op3", 2'd3, 6'd8, 32'h1234, 5);
    test_cmd("err_len0", 2'd1, 6'd0, 32'h1234, 5);
    test_cmd("err_len33", 2'd2, 6'd33, 32'h1234, 5);
  endtask

  task automatic test_back_to_back();
    test_cmd("b2b_first", 2'd2, 6'd5, $urandom, 0);
    test_cmd("b2b_second", 2'd1, 6'd7, $urandom, 0);
  endtask

  task automatic test_mid_reset();
    int w;
    pat = {$urandom, $urandom};
    @(negedge clk);
    tck_cnt = 0; tdo_q = pat[0];
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_len   = 6'd32;
    bus.cmd_data  = $urandom;
    w = 0;
    while (!bus.cmd_ready && w < 200) begin @(negedge clk); w++; end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    w = 0;
    while (tck_cnt < 10 && w < 1000) begin @(negedge clk); w++; end
    checks++;
    if (tck_cnt < 10) begin
      errors++; $display("FAIL mid_rst wait: got %0d TCKs expected 10", tck_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({jtag_tck, jtag_tms, jtag_tdi, jtag_trstn, bus.cmd_ready, bus.rsp_valid,
         bus.rsp_err, busy} !== 8'b0101_0001 || bus.rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst values: tck tms tdi trstn rdy vld err busy=%b%b%b%b%b%b%b%b data=%h expected 01010001 0",
               jtag_tck, jtag_tms, jtag_tdi, jtag_trstn, bus.cmd_ready,
               bus.rsp_valid, bus.rsp_err, busy, bus.rsp_data);
    end
    @(negedge clk);
    release_and_check_init("mid_rst_init");
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst dropped_rsp: rsp_valid=%b expected 0", bus.rsp_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_len   = 6'd0;
    bus.cmd_data  = 32'h0;
    bus.rsp_ready = 1'b0;
    pat = '0;
    test_reset();
    test_init_rst();
    test_scans();
    test_loopback();
    test_errors();
    test_back_to_back();
    test_mid_reset();
    test_cmd("after_mid_rst", 2'd2, 6'd16, $urandom, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
